// File: rtl/tvin_capture_pkg.sv
// Shared definitions for the TV-in capture block: register map,
// capture FSM states, register reset values and a small helper.
package tvin_pkg;

  // Register addresses on the SuperIO bus
  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_START_HI = 4'h1;
  localparam logic [3:0] REG_START_LO = 4'h2;
  localparam logic [3:0] REG_HOFF     = 4'h3;
  localparam logic [3:0] REG_VOFF     = 4'h4;
  localparam logic [3:0] REG_HSIZE    = 4'h5;
  localparam logic [3:0] REG_VSIZE    = 4'h6;
  localparam logic [3:0] REG_LINES_LO = 4'h7;
  localparam logic [3:0] REG_LINES_HI = 4'h8;

  // Window register defaults: a 320x200 window (40 chars x 200 lines)
  localparam logic [7:0] HOFF_RST  = 8'd96;
  localparam logic [7:0] VOFF_RST  = 8'd50;
  localparam logic [7:0] HSIZE_RST = 8'd39;
  localparam logic [7:0] VSIZE_RST = 8'd199;

  // Capture sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  // 9-bit increment that sticks at 511
  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/tvin_capture_if.sv
// Bundle of the CPU bus, the TV input stream and the capture RAM port.
// master = the CPU / stream / RAM side, slave = the capture block.
interface tvin_capture_if #(
  parameter int AW = 13
);
  logic [3:0]    AD;
  logic [7:0]    DI;
  logic [7:0]    DO;
  logic          rw;
  logic          cs;
  logic          irq;
  logic          pix_en;
  logic [1:0]    tvin;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_we;

  modport master (
    output AD, DI, rw, cs, pix_en, tvin,
    input  DO, irq, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  AD, DI, rw, cs, pix_en, tvin,
    output DO, irq, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/tvin_capture_syncsep.sv
// Sync separator: measures sync-tip length, classifies the pulse as
// hsync or vsync when sync returns high, and tracks sync lock.
// Event outputs are single-cycle and coincide with the pix_en sample
// on which sync returns to 1.
module tvin_syncsep #(
  parameter int HSYNC_MIN = 16,
  parameter int VSYNC_MIN = 96,
  parameter int TIMEOUT   = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pix_en,
  input  logic i_sync,
  output logic o_hs_evt,
  output logic o_vs_evt,
  output logic o_lock,
  output logic o_lock_drop
);

  logic [9:0] r_lowcnt;
  logic [9:0] r_tocnt;
  logic       r_lock;

  logic w_ret;
  logic w_vs;
  logic w_hs;
  logic w_evt;
  logic w_expire;

  assign w_ret    = i_pix_en & i_sync;
  assign w_vs     = w_ret && (r_lowcnt >= 10'(VSYNC_MIN));
  assign w_hs     = w_ret && !w_vs && (r_lowcnt >= 10'(HSYNC_MIN));
  assign w_evt    = w_vs | w_hs;
  // This sample is the TIMEOUT-th consecutive one without a sync event
  assign w_expire = i_pix_en && !w_evt && (({1'b0, r_tocnt} + 11'd1) >= 11'(TIMEOUT));

  assign o_hs_evt    = w_hs;
  assign o_vs_evt    = w_vs;
  assign o_lock      = r_lock;
  assign o_lock_drop = w_expire & r_lock;

  // Count consecutive sync-tip samples, saturating; clear when sync returns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lowcnt <= '0;
    end else if (i_pix_en) begin
      if (!i_sync) begin
        if (r_lowcnt != 10'h3FF) r_lowcnt <= r_lowcnt + 10'd1;
      end else begin
        r_lowcnt <= '0;
      end
    end
  end

  // Lock: any valid sync sets it, a long run without sync clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tocnt <= '0;
      r_lock  <= 1'b0;
    end else if (i_pix_en) begin
      if (w_evt) begin
        r_tocnt <= '0;
        r_lock  <= 1'b1;
      end else begin
        if (r_tocnt != 10'h3FF) r_tocnt <= r_tocnt + 10'd1;
        if (w_expire) r_lock <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/tvin_capture.sv
// TV-in capture: receives the {video, sync} stream, tracks line/pixel
// position, packs a programmable window of 1-bit pixels MSB first into
// bytes for a capture RAM, and exposes a small CPU register file with
// an end-of-frame interrupt.
module tvin_capture
  import tvin_pkg::*;
#(
  parameter int HSYNC_MIN = 16,
  parameter int VSYNC_MIN = 96,
  parameter int TIMEOUT   = 1023,
  parameter int AW        = 13
) (
  input  logic           clk,
  input  logic           rst,
  tvin_capture_if.slave  bus
);

  // Sync separator outputs
  logic w_hs;
  logic w_vs;
  logic w_lock;
  logic w_lock_drop;

  // Register file
  logic       r_ien;
  logic       r_irq;
  logic [4:0] r_start_hi;
  logic [7:0] r_start_lo;
  logic [7:0] r_hoff;
  logic [7:0] r_voff;
  logic [7:0] r_hsize;
  logic [7:0] r_vsize;
  logic [8:0] r_lines;

  // Position tracking
  logic [8:0] r_pixcnt;
  logic [8:0] r_linecnt;
  logic       r_hs_seen;

  // Capture FSM and packer
  cap_state_t    r_state;
  logic [AW-1:0] r_addr;
  logic [6:0]    r_sr;
  logic [2:0]    r_bitcnt;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [7:0]    r_mem_data;

  // Decoded bus strobes and derived values
  logic          w_video;
  logic          w_wr;
  logic          w_arm;
  logic          w_stat_rd;
  logic          w_busy;
  logic [AW-1:0] w_start;
  logic [12:0]   w_addr13;
  logic [7:0]    w_do;

  // Window compare; horizontal span reaches 8*256 so it needs 12 bits
  logic [11:0] w_pix12;
  logic [11:0] w_h_lo;
  logic [11:0] w_h_end;
  logic [9:0]  w_line10;
  logic [9:0]  w_v_lo;
  logic [9:0]  w_v_hi;
  logic        w_in_win;
  logic        w_last_line;

  tvin_syncsep #(
    .HSYNC_MIN (HSYNC_MIN),
    .VSYNC_MIN (VSYNC_MIN),
    .TIMEOUT   (TIMEOUT)
  ) u_syncsep (
    .clk         (clk),
    .rst         (rst),
    .i_pix_en    (bus.pix_en),
    .i_sync      (bus.tvin[0]),
    .o_hs_evt    (w_hs),
    .o_vs_evt    (w_vs),
    .o_lock      (w_lock),
    .o_lock_drop (w_lock_drop)
  );

  assign w_video   = bus.tvin[1];
  assign w_wr      = bus.cs & ~bus.rw;
  assign w_arm     = w_wr && (bus.AD == REG_CTRL) && bus.DI[0];
  assign w_stat_rd = bus.cs && bus.rw && (bus.AD == REG_CTRL);
  assign w_busy    = (r_state == ST_WAIT_VS) || (r_state == ST_ACTIVE);
  assign w_start   = AW'({r_start_hi, r_start_lo});
  assign w_addr13  = 13'(r_addr);

  assign w_pix12     = {3'b000, r_pixcnt};
  assign w_h_lo      = {4'b0000, r_hoff};
  assign w_h_end     = w_h_lo + {1'b0, r_hsize, 3'b000} + 12'd8;
  assign w_line10    = {1'b0, r_linecnt};
  assign w_v_lo      = {2'b00, r_voff};
  assign w_v_hi      = w_v_lo + {2'b00, r_vsize};
  assign w_in_win    = (w_pix12 >= w_h_lo) && (w_pix12 < w_h_end) &&
                       (w_line10 >= w_v_lo) && (w_line10 <= w_v_hi);
  assign w_last_line = (w_line10 >= w_v_hi);

  assign bus.DO       = w_do;
  assign bus.irq      = r_irq;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;

  // CPU writes to the register file; IRQ set has priority over the read-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ien      <= 1'b0;
      r_irq      <= 1'b0;
      r_start_hi <= '0;
      r_start_lo <= '0;
      r_hoff     <= HOFF_RST;
      r_voff     <= VOFF_RST;
      r_hsize    <= HSIZE_RST;
      r_vsize    <= VSIZE_RST;
    end else begin
      if (w_wr) begin
        case (bus.AD)
          REG_CTRL:     r_ien      <= bus.DI[6];
          REG_START_HI: r_start_hi <= bus.DI[4:0];
          REG_START_LO: r_start_lo <= bus.DI;
          REG_HOFF:     r_hoff     <= bus.DI;
          REG_VOFF:     r_voff     <= bus.DI;
          REG_HSIZE:    r_hsize    <= bus.DI;
          REG_VSIZE:    r_vsize    <= bus.DI;
          default:      ;
        endcase
      end
      if ((r_state == ST_DONE) && r_ien) r_irq <= 1'b1;
      else if (w_stat_rd)                r_irq <= 1'b0;
    end
  end

  // Read mux; address lines beyond the map return 0
  always_comb begin
    w_do = 8'h00;
    case (bus.AD)
      REG_CTRL:     w_do = {r_irq, r_ien, w_lock, w_busy, 4'b0000};
      REG_START_HI: w_do = {3'b000, w_addr13[12:8]};
      REG_START_LO: w_do = w_addr13[7:0];
      REG_HOFF:     w_do = r_hoff;
      REG_VOFF:     w_do = r_voff;
      REG_HSIZE:    w_do = r_hsize;
      REG_VSIZE:    w_do = r_vsize;
      REG_LINES_LO: w_do = r_lines[7:0];
      REG_LINES_HI: w_do = {7'b0000000, r_lines[8]};
      default:      w_do = 8'h00;
    endcase
  end

  // Pixel/line position and per-frame line total
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pixcnt  <= '0;
      r_linecnt <= '0;
      r_lines   <= '0;
      r_hs_seen <= 1'b0;
    end else if (bus.pix_en) begin
      if (w_hs) begin
        r_pixcnt  <= '0;
        r_linecnt <= sat_inc9(r_linecnt);
        r_hs_seen <= 1'b1;
      end else if (w_vs) begin
        r_pixcnt  <= sat_inc9(r_pixcnt);
        r_linecnt <= '0;
        r_hs_seen <= 1'b0;
        // Only the first broad pulse of a train closes the frame
        if (r_hs_seen) r_lines <= sat_inc9(r_linecnt);
      end else begin
        r_pixcnt <= sat_inc9(r_pixcnt);
      end
    end
  end

  // Capture sequencer with the bit packer and RAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_sr       <= '0;
      r_bitcnt   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_arm) begin
        // Arming (or re-arming) always restarts from the top of a frame
        r_state  <= ST_WAIT_VS;
        r_addr   <= w_start;
        r_bitcnt <= '0;
      end else if (w_lock_drop && w_busy) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_WAIT_VS: begin
            if (w_vs) begin
              r_state  <= ST_ACTIVE;
              r_bitcnt <= '0;
            end
          end
          ST_ACTIVE: begin
            if (w_vs || (w_hs && w_last_line)) begin
              r_state  <= ST_DONE;
              r_bitcnt <= '0;
            end else if (w_hs) begin
              // A partial byte at the end of the previous line is dropped
              r_bitcnt <= '0;
            end else if (bus.pix_en && w_in_win) begin
              r_sr     <= {r_sr[5:0], w_video};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_mem_we   <= 1'b1;
                r_mem_data <= {r_sr, w_video};
                r_mem_addr <= r_addr;
                r_addr     <= r_addr + AW'(1);
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
